// File: rtl/pipe_queue_pkg.sv
// -----------------------------------------------------------------------------
// cpuDefine : shared CPU-wide types.
//   ID_DATA    - payload carried from fetch into decode (one instruction word)
//   EXC_CODE   - exception message codes attached to front-end entries
//   IQ_DEPTH   - default depth of the fetch-to-decode instruction queue
//   IQ_ENTRY   - one queue slot: payload plus exception flag
//   ID_NOP     - canonical bubble payload (addi x0, x0, 0)
// -----------------------------------------------------------------------------
package cpuDefine;

  typedef logic [31:0] ID_DATA;

  typedef enum logic [3:0] {
    EXC_NONE           = 4'd0,
    EXC_IFETCH_MISALIGN = 4'd1,
    EXC_IFETCH_FAULT   = 4'd2,
    EXC_ILLEGAL_INSTR  = 4'd3
  } EXC_CODE;

  localparam int IQ_DEPTH = 4;

  typedef struct packed {
    ID_DATA data;
    logic   exc;
  } IQ_ENTRY;

  localparam ID_DATA ID_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_queue.sv
// -----------------------------------------------------------------------------
// pipe_queue : elastic buffer between two pipeline stages (e.g. IF -> ID).
// Both ends use the valid/allow stage handshake; a stall on one side is
// absorbed by up to DEPTH stored entries before it reaches the other side.
//
// Ports
//   aclk       clock, all state changes on the rising edge
//   aresetn    synchronous active-low reset
//   valid_in   producer presents an entry this cycle
//   data_in    producer payload
//   exc_in     producer entry carries an exception (payload stored as zero)
//   allow_out  queue can accept an entry this cycle (not full)
//   valid_out  head entry valid toward the consumer (not empty)
//   data_out   head payload, nop_data when empty
//   exc_out    head exception flag, 0 when empty
//   nop_data   payload shown on data_out while empty
//   allow_in   consumer accepts the head this cycle
//   flush      discard every entry (wins over a same-cycle push/pop)
//   count      current occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module pipe_queue
  import cpuDefine::*;
#(
  parameter type T     = ID_DATA,
  parameter int  DEPTH = IQ_DEPTH
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        valid_in,
  input  T                            data_in,
  input  logic                        exc_in,
  output logic                        allow_out,
  output logic                        valid_out,
  output T                            data_out,
  output logic                        exc_out,
  input  T                            nop_data,
  input  logic                        allow_in,
  input  logic                        flush,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    T     data;
    logic exc;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic            w_clear;
  entry_t          w_head;

  // Full/empty come from the counter alone, so allow_out has no path from
  // allow_in; pointers are free to wrap since DEPTH is a power of two.
  assign allow_out = (r_count != CW'(DEPTH));
  assign valid_out = (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign data_out  = valid_out ? w_head.data : nop_data;
  assign exc_out   = valid_out ? w_head.exc  : 1'b0;
  assign count     = r_count;

  assign w_push  = valid_in  & allow_out;
  assign w_pop   = valid_out & allow_in;
  assign w_clear = ~aresetn | flush;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every block sees the pre-edge values regardless of evaluation order.
  always_ff @(posedge aclk) begin
    if (w_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; count == 0 already hides stale slots, and a
  // reset-free array maps onto plain flops without a reset tree.
  // An exception entry keeps only its flag so no faulting payload leaks to
  // decode. Writes are suppressed during a clear since the entry is dropped.
  always_ff @(posedge aclk) begin
    if (w_push && !w_clear) begin
      r_mem[r_wr_ptr].data <= exc_in ? T'('0) : data_in;
      r_mem[r_wr_ptr].exc  <= exc_in;
    end
  end

endmodule

// File: tb/tb_pipe_queue.sv
// -----------------------------------------------------------------------------
// tb_pipe_queue : table-driven vectors, hand-written corner sequences and a
// randomized run against a queue-based reference model for pipe_queue.
// -----------------------------------------------------------------------------
module tb_pipe_queue;
  import cpuDefine::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        valid_in;
  logic [31:0] data_in;
  logic        exc_in;
  logic        allow_out;
  logic        valid_out;
  logic [31:0] data_out;
  logic        exc_out;
  logic [31:0] nop_data;
  logic        allow_in;
  logic        flush;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  pipe_queue #(.T(ID_DATA), .DEPTH(DEPTH)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .exc_in    (exc_in),
    .allow_out (allow_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .exc_out   (exc_out),
    .nop_data  (nop_data),
    .allow_in  (allow_in),
    .flush     (flush),
    .count     (count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        e;
    logic        a;
    logic        f;
    logic [2:0]  cnt;
    logic        vo;
    logic        ao;
    logic [31:0] dout;
    logic        eo;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } ent_t;

  vec_t vecs [12];
  ent_t model_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] cnt, input logic vo,
                            input logic ao, input logic [31:0] dout, input logic eo);
    check({tag, ".count"},     32'(count),     32'(cnt));
    check({tag, ".valid_out"}, 32'(valid_out), 32'(vo));
    check({tag, ".allow_out"}, 32'(allow_out), 32'(ao));
    check({tag, ".data_out"},  data_out,       dout);
    check({tag, ".exc_out"},   32'(exc_out),   32'(eo));
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
  task automatic drive(input logic v, input logic [31:0] d, input logic e,
                       input logic a, input logic f);
    valid_in = v;
    data_in  = d;
    exc_in   = e;
    allow_in = a;
    flush    = f;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    aresetn = 1'b1;
    model_q.delete();
  endtask

  initial begin
    logic [31:0] a_v, b_v, c_v, d_v, e_v, x_v, y_v;
    a_v = 32'hAAAA_0001; b_v = 32'hBBBB_0002; c_v = 32'hCCCC_0003;
    d_v = 32'hDDDD_0004; e_v = 32'hEEEE_0005; x_v = 32'hDEAD_BEEF; y_v = 32'h1234_5678;

    aresetn  = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    exc_in   = 1'b0;
    allow_in = 1'b0;
    flush    = 1'b0;
    nop_data = NOP;

    // ---------------- reset / idle ----------------
    do_reset();
    check_outs("reset", 3'd0, 1'b0, 1'b1, NOP, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_outs("idle", 3'd0, 1'b0, 1'b1, NOP, 1'b0);

    // ---------------- table: fill, overflow attempt, drain, exception ----
    //            v     d     e     a     f     cnt  vo    ao    dout  eo
    vecs[0]  = '{1'b1, a_v, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, a_v, 1'b0};
    vecs[1]  = '{1'b1, b_v, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, a_v, 1'b0};
    vecs[2]  = '{1'b1, c_v, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, a_v, 1'b0};
    vecs[3]  = '{1'b1, d_v, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, a_v, 1'b0};
    vecs[4]  = '{1'b1, e_v, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, a_v, 1'b0};
    vecs[5]  = '{1'b0, e_v, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, b_v, 1'b0};
    vecs[6]  = '{1'b0, e_v, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, c_v, 1'b0};
    vecs[7]  = '{1'b0, e_v, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, d_v, 1'b0};
    vecs[8]  = '{1'b0, e_v, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, NOP, 1'b0};
    vecs[9]  = '{1'b1, x_v, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h0, 1'b1};
    vecs[10] = '{1'b1, y_v, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, y_v, 1'b0};
    vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, NOP, 1'b0};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].e, vecs[i].a, vecs[i].f);
      check_outs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].vo, vecs[i].ao,
                 vecs[i].dout, vecs[i].eo);
    end

    // ---------------- steady stream across pointer wrap ----------------
    do_reset();
    drive(1'b1, 32'h5000_0000, 1'b0, 1'b0, 1'b0);
    check_outs("stream.seed", 3'd1, 1'b1, 1'b1, 32'h5000_0000, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 32'h5000_0000 + 32'(k), 1'b0, 1'b1, 1'b0);
      // After popping the previous head, only this cycle's entry remains.
      check($sformatf("stream%0d.count", k), 32'(count), 32'd1);
      check($sformatf("stream%0d.data", k), data_out, 32'h5000_0000 + 32'(k));
    end

    // ---------------- flush priority ----------------
    do_reset();
    drive(1'b1, 32'hF000_0001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hF000_0002, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hF000_0003, 1'b0, 1'b0, 1'b0);
    check("flush.pre.allow_out", 32'(allow_out), 32'd1);
    drive(1'b1, 32'hF000_00FF, 1'b0, 1'b1, 1'b1);
    check_outs("flush.after", 3'd0, 1'b0, 1'b1, NOP, 1'b0);
    drive(1'b1, 32'h6000_0006, 1'b0, 1'b0, 1'b0);
    check_outs("flush.g", 3'd1, 1'b1, 1'b1, 32'h6000_0006, 1'b0);

    // ---------------- reset mid-stream ----------------
    drive(1'b1, 32'h7000_0007, 1'b0, 1'b0, 1'b0);
    aresetn = 1'b0;
    drive(1'b1, 32'h7000_0008, 1'b0, 1'b1, 1'b0);
    aresetn = 1'b1;
    check_outs("midreset", 3'd0, 1'b0, 1'b1, NOP, 1'b0);

    // ---------------- randomized vs queue model ----------------
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic        v, e, a, f;
      logic [31:0] d;
      bit          do_push, do_pop;
      ent_t        ent;
      v = ($urandom_range(0, 9) < 7);
      e = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 1) == 1);
      f = ($urandom_range(0, 31) == 0);
      d = $urandom;
      do_push = v && (model_q.size() < DEPTH);
      do_pop  = a && (model_q.size() > 0);
      drive(v, d, e, a, f);
      if (f) begin
        model_q.delete();
      end else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
          ent.d = e ? 32'h0 : d;
          ent.e = e;
          model_q.push_back(ent);
        end
      end
      if (model_q.size() == 0)
        check_outs($sformatf("rnd%0d", n), 3'd0, 1'b0, 1'b1, NOP, 1'b0);
      else
        check_outs($sformatf("rnd%0d", n), 3'(model_q.size()), 1'b1,
                   (model_q.size() < DEPTH), model_q[0].d, model_q[0].e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_queue.md
Name: pipe_queue

Overview:
- Elastic multi-entry buffer that sits between two pipeline stages, e.g. between IF and ID as an instruction queue.
- Both ends use the valid/allow handshake of the pipeline stage registers:
  - It is the consumer (downstream end) for the producing stage.
  - It is the producer (upstream end) for the consuming stage.
- Decouples the two stages so a stall on one side does not immediately stall the other.
- Supports flush, and carries a per-entry exception flag next to the data.

Parameters:
- T, ID_DATA: entry payload type, from package cpuDefine.
- DEPTH, 4: number of entries. Must be a power of two and at least 2.
- CW, $clog2(DEPTH)+1: width of the occupancy counter. Derived; never overridden.

Ports:
- aclk  in  1  clock. All state changes on the rising edge.
- aresetn  in  1  reset. Synchronous, active-low.
- valid_in  in  1  producer presents an entry this cycle.
- data_in  in  T  producer payload.
- exc_in  in  1  producer entry carries an exception.
- allow_out  out  1  queue can accept an entry this cycle.
- valid_out  out  1  head entry valid toward the consumer.
- data_out  out  T  head payload, or nop_data when the queue is empty.
- exc_out  out  1  exception flag of the head entry. 0 when empty.
- nop_data  in  T  payload driven on data_out when the queue is empty.
- allow_in  in  1  consumer accepts the head this cycle.
- flush  in  1  discard all entries.
- count  out  CW  current occupancy, 0..DEPTH.

Behaviour:
- State:
  - storage array mem[DEPTH] of {T, exc}
  - rd_ptr and wr_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH
  - count, CW bits
- Combinational outputs:
  - allow_out = (count != DEPTH). It depends only on registered state; there is no combinational path from allow_in to allow_out.
  - valid_out = (count != 0).
  - data_out = mem[rd_ptr].data when count != 0, else nop_data.
  - exc_out = mem[rd_ptr].exc when count != 0, else 0.
- Handshake events:
  - push = valid_in & allow_out
  - pop = valid_out & allow_in
- Push:
  - mem[wr_ptr] <= {exc_in ? '0 : data_in, exc_in}. An entry with an exception is stored with zeroed payload.
  - wr_ptr <= wr_ptr + 1.
- Pop:
  - rd_ptr <= rd_ptr + 1.
  - Entry contents are left in place.
- Count update:
  - push only: +1
  - pop only: -1
  - both, or neither: unchanged
- Simultaneous push and pop:
  - Legal at every occupancy 1..DEPTH-1; count is unchanged.
  - When full, allow_out = 0, so no push happens and only a pop is possible.
  - When empty, valid_out = 0, so no pop happens and only a push is possible.
  - There is no bypass: an entry pushed into an empty queue appears on valid_out the next cycle. Minimum latency is 1 cycle.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no special handling. Full and empty are distinguished by count only.
- Flush:
  - Condition: (~aresetn | flush) at the clock edge.
  - Next cycle: rd_ptr = wr_ptr = 0 and count = 0.
  - Flush takes priority over a same-cycle push and pop. The pushed entry is dropped, although allow_out was 1 that cycle.
  - mem contents need not be cleared.
- Reset values: count = 0, so after reset valid_out = 0, allow_out = 1, data_out = nop_data, exc_out = 0.
- Reset or flush mid-stream: every in-flight entry is lost. The producer re-presents from the redirect target.
- Holding rules:
  - Consumer: data_out/exc_out stay stable while valid_out = 1 and allow_in = 0.
  - Producer: the queue does not rely on valid_in being held. Each cycle is sampled independently.
- No error outputs. A push while full cannot occur because of allow_out gating.

Decomposition:
- Package cpuDefine:
  - Holds T types (ID_DATA) and the exception message types.
  - Add localparam IQ_DEPTH = 4 and a packed struct IQ_ENTRY {T data; logic exc;}. The struct is used as a typedef inside the module, parameterised by T.
- Single module. No sub-module is required. Storage is a plain register array; it is not an SRAM macro.

Test Plan (DEPTH=4, nop_data = 32'h0000_0013 payload pattern):
- Reset, then idle:
  - Response: count=0, valid_out=0, allow_out=1, data_out=nop_data.
- Fill with no consumer:
  - Stimulus: push A,B,C,D on 4 consecutive cycles with allow_in=0.
  - Response: count reaches 4 and allow_out=0. A 5th valid_in (E) is not accepted. data_out=A throughout.
- Drain:
  - Stimulus: starting from full, allow_in=1 for 4 cycles.
  - Response: data_out shows A,B,C,D in order, then count=0 and valid_out=0.
- Steady stream with wrap:
  - Stimulus: valid_in=1 and allow_in=1 every cycle for 10 cycles, starting from 1 entry.
  - Response: count stays 1. Output order equals input order across pointer wrap (wr_ptr 3 to 0).
- Flush priority:
  - Stimulus: 3 entries held, then flush=1 in a cycle with push F and pop.
  - Response: next cycle count=0, valid_out=0, F absent. A push G on the following cycle appears as the head one cycle later.
- Exception entry:
  - Stimulus: push data_in=32'hDEAD_BEEF with exc_in=1.
  - Response: at the head, data_out=0 and exc_out=1. The next normal entry has exc_out=0.
